// File: rtl/dec_bank_pkg.sv
// Shared types and helpers for the rotating decision bank RAM.
// Bank index type, safe clog2 and modulo bank increment.
package dec_bank_pkg;

  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int MAX_BANKS  = 16;
  localparam int BANK_IDX_W = clog2_safe(MAX_BANKS);

  typedef logic [BANK_IDX_W-1:0] bank_idx_t;

  function automatic bank_idx_t next_bank(
    input bank_idx_t idx,
    input int        n
  );
    if (int'(idx) >= n - 1) return '0;
    return idx + bank_idx_t'(1);
  endfunction

endpackage

// File: rtl/RAM_SP_SR_RW.sv
// Single-port RAM, synchronous read and write, one port.
// Ports: clk, cs, we, addr, din -> dout (registered, updated on cs && !we).
module RAM_SP_SR_RW #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  cs,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (cs && we)
      r_mem[addr] <= din;
    if (cs && !we)
      dout <= r_mem[addr];
  end

endmodule

// File: rtl/dec_bank_ram.sv
// N-bank rotating decision RAM: writer fills/commits banks, reader reads/releases.
// Ports: wr_* write side, rd_* read side, bank_count, sticky err_wr/err_rd.
module dec_bank_ram
  import dec_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int NUM_BANKS  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             wr_commit,
  output logic                             wr_ready,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  input  logic                             rd_release,
  output logic                             rd_avail,
  output logic [$clog2(NUM_BANKS+1)-1:0]   bank_count,
  output logic                             err_wr,
  output logic                             err_rd
);

  localparam int CNT_W = $clog2(NUM_BANKS + 1);

  bank_idx_t             r_wr_ptr;
  bank_idx_t             r_rd_ptr;
  bank_idx_t             r_rd_bank;
  logic [CNT_W-1:0]      r_count;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_err_wr;
  logic                  r_err_rd;

  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic                  w_we;
  logic                  w_inc;
  logic                  w_dec;
  logic                  w_rd;
  logic [DATA_WIDTH-1:0] w_mux;
  logic [DATA_WIDTH-1:0] w_dout [NUM_BANKS];

  assign w_wr_ok = (r_count < CNT_W'(NUM_BANKS));
  assign w_rd_ok = (r_count != '0);
  assign w_we    = wr_en && w_wr_ok;
  assign w_inc   = wr_commit && w_wr_ok;
  assign w_dec   = rd_release && w_rd_ok;
  assign w_rd    = rd_en && w_rd_ok;

  // When full the write pointer aliases the read bank; the reader
  // owns it then, so the write address is only steered in while ready.
  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    logic                  w_sel;
    logic [ADDR_WIDTH-1:0] w_addr;
    assign w_sel  = (r_wr_ptr == bank_idx_t'(i)) && w_wr_ok;
    assign w_addr = w_sel ? wr_addr : rd_addr;

    RAM_SP_SR_RW #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .RAM_DEPTH  (RAM_DEPTH)
    ) u_ram (
      .clk  (clk),
      .cs   (1'b1),
      .we   (w_we && w_sel),
      .addr (w_addr),
      .din  (wr_data),
      .dout (w_dout[i])
    );
  end

  always_comb begin
    w_mux = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      if (r_rd_bank == bank_idx_t'(i))
        w_mux = w_dout[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_bank  <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_hold     <= '0;
      r_err_wr   <= 1'b0;
      r_err_rd   <= 1'b0;
    end else begin
      if (w_inc)
        r_wr_ptr <= next_bank(r_wr_ptr, NUM_BANKS);
      if (w_dec)
        r_rd_ptr <= next_bank(r_rd_ptr, NUM_BANKS);
      r_count <= r_count + CNT_W'(w_inc) - CNT_W'(w_dec);
      r_rd_valid <= w_rd;
      if (w_rd)
        r_rd_bank <= r_rd_ptr;
      // Capture the presented word so rd_data holds between reads.
      if (r_rd_valid)
        r_hold <= w_mux;
      if ((wr_en || wr_commit) && !w_wr_ok)
        r_err_wr <= 1'b1;
      if ((rd_en || rd_release) && !w_rd_ok)
        r_err_rd <= 1'b1;
    end
  end

  assign wr_ready   = w_wr_ok;
  assign rd_avail   = w_rd_ok;
  assign bank_count = r_count;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_valid ? w_mux : r_hold;
  assign err_wr     = r_err_wr;
  assign err_rd     = r_err_rd;

endmodule
